// File: rtl/ssds_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package ssds_pkg;

    localparam int unsigned SEGMENT_COUNT = 7;
    localparam int unsigned NIBBLE_W      = 4;

    typedef logic [3:0] ssds_nibble_t;
    typedef logic [6:0] ssds_segments_t;

    // Segment bit positions inside ssds_segments_t
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

endpackage : ssds_pkg

// File: rtl/ssds_digit_mapper.sv
// Hex nibble to active-high seven-segment pattern (bit0=a .. bit6=g).
// Ports:
//   nibble_i   - hex digit 0..F
//   segments_c - combinational segment pattern, 1 = segment lit
module ssds_digit_mapper
    import ssds_pkg::*;
(
    input  ssds_nibble_t   nibble_i,
    output ssds_segments_t segments_c
);

    // Patterns listed as {g,f,e,d,c,b,a}; letters b and d are lowercase shapes
    always_comb begin
        segments_c = '0;
        case (nibble_i)
            4'h0: segments_c = 7'b0111111;
            4'h1: segments_c = 7'b0000110;
            4'h2: segments_c = 7'b1011011;
            4'h3: segments_c = 7'b1001111;
            4'h4: segments_c = 7'b1100110;
            4'h5: segments_c = 7'b1101101;
            4'h6: segments_c = 7'b1111101;
            4'h7: segments_c = 7'b0000111;
            4'h8: segments_c = 7'b1111111;
            4'h9: segments_c = 7'b1101111;
            4'hA: segments_c = 7'b1110111;
            4'hB: segments_c = 7'b1111100;
            4'hC: segments_c = 7'b0111001;
            4'hD: segments_c = 7'b1011110;
            4'hE: segments_c = 7'b1111001;
            4'hF: segments_c = 7'b1110001;
        endcase
    end

endmodule : ssds_digit_mapper

// File: rtl/ssds_scan_timer.sv
// Prescaler and slot counter for the digit scan.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   enable_i       - 0 holds prescaler and slot at 0
//   slot_o         - current digit slot (registered)
//   blank_c        - current cycle lies in the inter-digit blank window
//   frame_start_c  - current cycle is a frame boundary (slot wrap, or first
//                    enabled cycle after reset/disable)
module ssds_scan_timer
    import ssds_pkg::*;
#(
    parameter  int unsigned DIGITS       = 4,
    parameter  int unsigned SCAN_DIVIDER = 50000,
    parameter  int unsigned BLANK_CYCLES = 500,
    localparam int unsigned SLOT_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic              blank_c,
    output logic              frame_start_c
);

    localparam int unsigned        PRE_W     = $clog2(SCAN_DIVIDER);
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(SCAN_DIVIDER - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(DIGITS - 1);

    logic [PRE_W-1:0]  pre_q,  pre_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              en_q;
    logic              tc;
    logic              slot_last;

    assign tc        = (pre_q == PRE_LAST);
    assign slot_last = (slot_q == SLOT_LAST);

    // Increment-and-wrap counters, forced to 0 while disabled
    always_comb begin
        pre_d  = pre_q;
        slot_d = slot_q;
        if (!enable_i) begin
            pre_d  = '0;
            slot_d = '0;
        end else if (tc) begin
            pre_d  = '0;
            slot_d = slot_last ? '0 : slot_q + SLOT_W'(1);
        end else begin
            pre_d  = pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            slot_q <= '0;
            en_q   <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            slot_q <= slot_d;
            en_q   <= enable_i;
        end
    end

    // Restarting the scan counts as a boundary so a pending value lands in slot 0
    assign frame_start_c = enable_i && (!en_q || (tc && slot_last));
    assign slot_o        = slot_q;

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign blank_c = 1'b0;
        end else begin : g_blank
            assign blank_c = (pre_q < PRE_W'(BLANK_CYCLES));
        end
    endgenerate

endmodule : ssds_scan_timer

// File: rtl/ssds_scan_controller.sv
// Time-multiplexed seven-segment display driver with frame-synchronous
// value updates, inter-digit blanking and leading-zero suppression.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   value        - 4 bits per digit, digit 0 (rightmost) in the low nibble
//   dots         - decimal point per digit
//   load         - one-cycle strobe capturing value/dots
//   enable       - 0 blanks the display and parks the scan at slot 0
//   lz_suppress  - 1 blanks leading zero digits
//   segments     - a..g (bit0..bit6), registered, polarity per ACTIVE_LOW
//   dot          - decimal point, registered, polarity per ACTIVE_LOW
//   selects      - one-hot digit enable, registered, polarity per ACTIVE_LOW
module ssds_scan_controller
    import ssds_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SCAN_DIVIDER = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*DIGITS-1:0]    value,
    input  logic [DIGITS-1:0]      dots,
    input  logic                   load,
    input  logic                   enable,
    input  logic                   lz_suppress,
    output ssds_segments_t         segments,
    output logic                   dot,
    output logic [DIGITS-1:0]      selects
);

    localparam int unsigned VAL_W  = NIBBLE_W * DIGITS;
    localparam int unsigned SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SLOT_W-1:0] slot;
    logic              blank;
    logic              frame_start;

    ssds_scan_timer #(
        .DIGITS       (DIGITS),
        .SCAN_DIVIDER (SCAN_DIVIDER),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable),
        .slot_o        (slot),
        .blank_c       (blank),
        .frame_start_c (frame_start)
    );

    logic [VAL_W-1:0]  disp_val_q,  disp_val_d;
    logic [DIGITS-1:0] disp_dots_q, disp_dots_d;
    logic [VAL_W-1:0]  pend_val_q,  pend_val_d;
    logic [DIGITS-1:0] pend_dots_q, pend_dots_d;
    logic              pend_valid_q, pend_valid_d;

    // Double-buffered value: display register only changes on a frame boundary
    always_comb begin
        disp_val_d   = disp_val_q;
        disp_dots_d  = disp_dots_q;
        pend_val_d   = pend_val_q;
        pend_dots_d  = pend_dots_q;
        pend_valid_d = pend_valid_q;
        if (load) begin
            pend_val_d  = value;
            pend_dots_d = dots;
        end
        if (frame_start) begin
            // A load coinciding with the boundary bypasses the pending stage
            if (load) begin
                disp_val_d  = value;
                disp_dots_d = dots;
            end else if (pend_valid_q) begin
                disp_val_d  = pend_val_q;
                disp_dots_d = pend_dots_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_val_q   <= '0;
            disp_dots_q  <= '0;
            pend_val_q   <= '0;
            pend_dots_q  <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            disp_val_q   <= disp_val_d;
            disp_dots_q  <= disp_dots_d;
            pend_val_q   <= pend_val_d;
            pend_dots_q  <= pend_dots_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    logic [DIGITS-1:0] suppress_c;
    logic              zero_run;

    // Walk down from the most significant digit while nibbles stay zero;
    // a dot keeps its own digit visible but does not stop the run below it
    always_comb begin
        suppress_c = '0;
        zero_run   = lz_suppress;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_run      = zero_run && (disp_val_q[NIBBLE_W*i +: NIBBLE_W] == 4'h0);
            suppress_c[i] = zero_run && !disp_dots_q[i];
        end
    end

    ssds_nibble_t      cur_nibble;
    logic              cur_dot;
    logic              cur_supp;
    logic [DIGITS-1:0] cur_sel;
    ssds_segments_t    mapped_segs;

    // Current-slot digit mux
    always_comb begin
        cur_nibble = '0;
        cur_dot    = 1'b0;
        cur_supp   = 1'b0;
        cur_sel    = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (slot == SLOT_W'(i)) begin
                cur_nibble = disp_val_q[NIBBLE_W*i +: NIBBLE_W];
                cur_dot    = disp_dots_q[i];
                cur_supp   = suppress_c[i];
                cur_sel[i] = 1'b1;
            end
        end
    end

    ssds_digit_mapper u_mapper (
        .nibble_i   (cur_nibble),
        .segments_c (mapped_segs)
    );

    ssds_segments_t    segments_q, segments_d;
    logic              dot_q,      dot_d;
    logic [DIGITS-1:0] selects_q,  selects_d;

    // Output stage: active-high decode, then pin polarity
    always_comb begin
        segments_d = '0;
        dot_d      = 1'b0;
        selects_d  = '0;
        if (enable && !blank && !cur_supp) begin
            segments_d = mapped_segs;
            dot_d      = cur_dot;
            selects_d  = cur_sel;
        end
        if (ACTIVE_LOW) begin
            segments_d = ~segments_d;
            dot_d      = ~dot_d;
            selects_d  = ~selects_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segments_q <= {SEGMENT_COUNT{ACTIVE_LOW}};
            dot_q      <= ACTIVE_LOW;
            selects_q  <= {DIGITS{ACTIVE_LOW}};
        end else begin
            segments_q <= segments_d;
            dot_q      <= dot_d;
            selects_q  <= selects_d;
        end
    end

    assign segments = segments_q;
    assign dot      = dot_q;
    assign selects  = selects_q;

endmodule : ssds_scan_controller

// File: tb/tb_ssds_scan_controller.sv
// Self-checking bench for ssds_scan_controller (4 digits, 4-cycle slots,
// 1 blank cycle, active-high pins).
module tb_ssds_scan_controller;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIVIDER = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int FRAME        = DIGITS * SCAN_DIVIDER;

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b1;
    logic [15:0] value       = '0;
    logic [3:0]  dots        = '0;
    logic        load        = 1'b0;
    logic        enable      = 1'b0;
    logic        lz_suppress = 1'b0;
    logic [6:0]  segments;
    logic        dot;
    logic [3:0]  selects;

    int n_checks = 0;
    int n_pass   = 0;

    ssds_scan_controller #(
        .DIGITS       (DIGITS),
        .SCAN_DIVIDER (SCAN_DIVIDER),
        .BLANK_CYCLES (BLANK_CYCLES),
        .ACTIVE_LOW   (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .dots        (dots),
        .load        (load),
        .enable      (enable),
        .lz_suppress (lz_suppress),
        .segments    (segments),
        .dot         (dot),
        .selects     (selects)
    );

    always #5 clk = ~clk;

    // Reference model: position within the frame plus the two value buffers
    int          m_pos;
    bit          m_en_prev;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_ddots, m_pdots;
    bit          m_pv;
    logic [11:0] m_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pos = 0; m_en_prev = 0; m_disp = '0; m_pend = '0;
        m_ddots = '0; m_pdots = '0; m_pv = 0; m_exp = '0;
    endtask

    function automatic logic [11:0] model_out();
        logic [1:0]  s2;
        int          ph;
        logic [15:0] upper;
        logic [3:0]  nib;
        s2    = 2'(m_pos / SCAN_DIVIDER);
        ph    = m_pos % SCAN_DIVIDER;
        upper = m_disp >> (4 * s2);
        nib   = upper[3:0];
        if (!enable || ph < BLANK_CYCLES) return '0;
        if (lz_suppress && s2 != 2'd0 && upper == 16'h0 && !m_ddots[s2]) return '0;
        return {HEX[nib], m_ddots[s2], 4'b0001 << s2};
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then compare
    task automatic tick();
        bit boundary;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_exp    = model_out();
            boundary = enable && (!m_en_prev || m_pos == FRAME - 1);
            if (boundary) begin
                if (load) begin
                    m_disp = value; m_ddots = dots;
                end else if (m_pv) begin
                    m_disp = m_pend; m_ddots = m_pdots;
                end
                m_pv = 0;
            end else if (load) begin
                m_pv = 1;
            end
            if (load) begin
                m_pend = value; m_pdots = dots;
            end
            m_en_prev = enable;
            m_pos     = enable ? (m_pos + 1) % FRAME : 0;
        end
        #1;
        check("scan", 32'({segments, dot, selects}), 32'(m_exp));
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (m_pos != p && n < 64) begin
            tick();
            n++;
        end
        if (m_pos != p) check("wait_pos_timeout", 32'(m_pos), 32'(p));
    endtask

    function automatic logic [3:0] rand_nib();
        return ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    endfunction

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dots;
        logic            lz;
        logic [3:0][6:0] segs;      // segs[i] is the pattern in slot i
        logic [3:0]      dot_exp;
        logic [3:0]      shown;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] sel_exp;
        logic [6:0] seg_exp;
        logic [1:0] si;
        int         seen1;

        vecs[0] = '{16'h12AF, 4'b0100, 1'b0, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0100, 4'b1111};
        vecs[1] = '{16'h0005, 4'b0000, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h6D}, 4'b0000, 4'b0001};
        vecs[2] = '{16'h0005, 4'b0010, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h6D}, 4'b0010, 4'b0011};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, 4'b0001};
        vecs[4] = '{16'h8070, 4'b0000, 1'b1, {7'h7F, 7'h3F, 7'h07, 7'h3F}, 4'b0000, 4'b1111};
        vecs[5] = '{16'h00C0, 4'b0000, 1'b1, {7'h3F, 7'h3F, 7'h39, 7'h3F}, 4'b0000, 4'b0011};
        vecs[6] = '{16'h3E9B, 4'b0000, 1'b0, {7'h4F, 7'h79, 7'h6F, 7'h7C}, 4'b0000, 4'b1111};
        vecs[7] = '{16'h0000, 4'b1000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1000, 4'b1111};
        vecs[8] = '{16'h0000, 4'b1000, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1000, 4'b1001};

        model_reset();

        // Reset state
        #1 rst_n = 1'b0;
        #1 check("reset_outputs", 32'({segments, dot, selects}), 32'h0);
        tick();
        tick();
        enable = 1'b1;
        rst_n  = 1'b1;

        // Zero display after reset: blank cycle, then digit 0 in slot 0
        tick();
        check("post_reset_blank_sel", 32'(selects), 32'h0);
        tick();
        check("post_reset_seg", 32'(segments), 32'h3F);
        check("post_reset_sel", 32'(selects), 32'h1);
        wait_pos(0);

        // Table: load a value, wait for the frame that shows it, probe each slot
        for (int v = 0; v < 9; v++) begin
            lz_suppress = vecs[v].lz;
            value = vecs[v].value;
            dots  = vecs[v].dots;
            load  = 1'b1;
            tick();
            load  = 1'b0;
            wait_pos(0);
            for (int s = 0; s < DIGITS; s++) begin
                si = 2'(s);
                wait_pos(s * SCAN_DIVIDER + 2);
                tick();
                seg_exp = vecs[v].shown[si] ? vecs[v].segs[si] : 7'h00;
                sel_exp = vecs[v].shown[si] ? (4'b0001 << si) : 4'b0000;
                check($sformatf("vec%0d_slot%0d_seg", v, s), 32'(segments), 32'(seg_exp));
                check($sformatf("vec%0d_slot%0d_sel", v, s), 32'(selects), 32'(sel_exp));
                check($sformatf("vec%0d_slot%0d_dot", v, s), 32'(dot), 32'(vecs[v].dot_exp[si]));
            end
        end

        // Two loads in one frame: only the second is ever shown
        lz_suppress = 1'b0;
        dots = 4'b0000;
        wait_pos(3);
        value = 16'h1111; load = 1'b1; tick(); load = 1'b0;
        wait_pos(7);
        value = 16'h2222; load = 1'b1; tick(); load = 1'b0;
        seen1 = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (segments == 7'h06 && selects != 4'h0) seen1++;
        end
        check("collide_never_1111", 32'(seen1), 32'h0);
        wait_pos(2);
        tick();
        check("collide_shows_2222", 32'(segments), 32'h5B);

        // Load on the boundary cycle goes straight into the next frame
        wait_pos(FRAME - 1);
        value = 16'h3333; load = 1'b1; tick(); load = 1'b0;
        wait_pos(2);
        tick();
        check("boundary_load_3333", 32'(segments), 32'h4F);

        // Enable drop mid-slot 2, load while disabled, restart at slot 0
        wait_pos(9);
        tick();
        enable = 1'b0;
        tick();
        check("enable_off_outputs", 32'({segments, dot, selects}), 32'h0);
        value = 16'h4444; load = 1'b1; tick(); load = 1'b0;
        tick();
        tick();
        enable = 1'b1;
        tick();
        check("enable_restart_blank", 32'(selects), 32'h0);
        tick();
        check("enable_restart_sel", 32'(selects), 32'h1);
        check("enable_restart_seg", 32'(segments), 32'h66);

        // Asynchronous reset mid-frame with a pending load
        wait_pos(5);
        value = 16'hBEEF; load = 1'b1; tick(); load = 1'b0;
        wait_pos(6);
        tick();
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", 32'({segments, dot, selects}), 32'h0);
        tick();
        rst_n = 1'b1;
        wait_pos(2);
        tick();
        check("post_async_seg", 32'(segments), 32'h3F);
        wait_pos(FRAME - 2);
        tick();
        wait_pos(2);
        tick();
        check("pending_lost_seg", 32'(segments), 32'h3F);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int r;
            r    = int'($urandom_range(0, 99));
            load = (r < 12);
            if (load) begin
                value = {rand_nib(), rand_nib(), rand_nib(), rand_nib()};
                dots  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            end
            if (!enable && r >= 70) enable = 1'b1;
            else if (enable && r == 99) enable = 1'b0;
            if ($urandom_range(0, 63) == 0) lz_suppress = ~lz_suppress;
            tick();
        end
        load = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ssds_scan_controller

// File: doc/ssds_scan_controller.md
# ssds_scan_controller

Time-multiplexed driver for a bank of common-anode/cathode seven-segment displays. Holds a multi-digit hex value and per-digit dots, scans one digit per time slot, and passes the active nibble through `ssds_digit_mapper` to the shared segment lines. It adds inter-digit blanking against ghosting and tear-free, frame-synchronous value updates. It sits between the CPU-facing display register and the board pins.

## Interface
- `DIGITS`, 4: number of display positions; ≥1.
- `SCAN_DIVIDER`, 50000: clock cycles per digit slot; ≥2.
- `BLANK_CYCLES`, 500: cycles at slot start with all selects inactive; < `SCAN_DIVIDER`.
- `ACTIVE_LOW`, 1: when 1, `segments`, `dot` and `selects` are driven active-low; when 0, active-high.
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `value` in 4·DIGITS: nibble i drives digit i; digit 0 is rightmost.
- `dots` in DIGITS: bit i lights the dot of digit i.
- `load` in 1: single-cycle strobe; captures `value`/`dots` into the pending register.
- `enable` in 1: 0 forces all outputs inactive and holds the scan at slot 0.
- `lz_suppress` in 1: 1 blanks leading zero digits.
- `segments` out 7: bit0=a … bit6=g, at the configured polarity.
- `dot` out 1: decimal point, at the configured polarity.
- `selects` out DIGITS: one-hot digit enable, at the configured polarity.

## Operation
- **Prescaler** counts 0..SCAN_DIVIDER-1 and wraps. At terminal count, the slot index advances. The slot wraps from DIGITS-1 to 0; that wrap is the frame boundary.
- **Value path:** `load` copies `value`/`dots` into the pending register and sets `pending_valid`. At a frame boundary with `pending_valid`=1, the pending register is copied to the display register and `pending_valid` clears.
  - Repeated loads within a frame: the last one wins.
  - `load` in the same cycle as the frame boundary: the incoming `value`/`dots` go straight to the display register, and `pending_valid` ends at 0.
- **Leading-zero suppression:** digit i (i>0) is blanked when `lz_suppress`=1, every display nibble from index DIGITS-1 down to i is 0, and `dots[i]`=0. Digit 0 is never suppressed.
- **Output stage:** the display nibble for the current slot goes through `ssds_digit_mapper`. Outputs are registered, then polarity-inverted if `ACTIVE_LOW`.
  - During a blank window, or for a suppressed digit: selects are all inactive, segments are inactive, and dot is inactive.
  - Otherwise: the select for the current slot is active.
- **enable=0:**
  - Prescaler and slot are held at 0.
  - Outputs are inactive.
  - `load` is still accepted.
  - When `enable` returns to 1, the first cycle counts as a frame boundary, so a pending value is applied.
- **Reset:**
  - Prescaler, slot, display and pending registers are 0; `pending_valid`=0.
  - All outputs are at their inactive level: all ones if `ACTIVE_LOW`=1, else zeros.
  - Reset asserted mid-frame aborts the frame and discards any pending value.
- **Widths:**
  - Prescaler: $clog2(SCAN_DIVIDER) bits.
  - Slot: max(1, $clog2(DIGITS)) bits.
  - No arithmetic beyond the increment-and-wrap counters.

## Timing
- Slot k occupies prescaler cycles 0..SCAN_DIVIDER-1.
- Outputs lag the internal slot/prescaler state by exactly 1 cycle (register stage).
- Select is active for SCAN_DIVIDER−BLANK_CYCLES cycles per slot.
- Frame period is DIGITS·SCAN_DIVIDER cycles.
- Load-to-display latency: up to one frame plus 1 cycle, and never mid-frame. Digits within one frame always come from the same load.

## Structure
- Package `ssds_pkg` holds:
  - `SEGMENT_COUNT`=7;
  - `typedef logic [3:0] ssds_nibble_t`;
  - `typedef logic [6:0] ssds_segments_t`;
  - segment bit-index constants `SEG_A`..`SEG_G`.
- Instantiates one `ssds_digit_mapper` on the selected display nibble.
- Prescaler/slot counter may be a sub-module `ssds_scan_timer` with outputs `slot`, `slot_start`, `blank` and `frame_start`.

## Test plan
All scenarios use DIGITS=4, SCAN_DIVIDER=4, BLANK_CYCLES=1, ACTIVE_LOW=0.
- **Reset:** hold `rst_n`=0 → `segments`=0, `dot`=0, `selects`=0. Release with `enable`=1 and display value 0 → each 4-cycle slot shows 1 blank cycle, then `segments`=7'b0111111 with `selects`=0001, 0010, 0100, 1000 in turn.
- **Value:** `load` with `value`=16'h12AF, `dots`=4'b0100 mid-frame → no change until the next slot-0 start. Then slot 0 shows 7'b1110001, slot 1 7'b1110111, slot 2 7'b1011011 with `dot`=1, slot 3 7'b0000110.
- **Load collisions:** `load` 16'h1111 then `load` 16'h2222 within one frame → only 2222 is ever displayed. `load` 16'h3333 exactly on the frame-boundary cycle → 3333 is shown in that frame.
- **Leading zeros:** `lz_suppress`=1, `value`=16'h0005, `dots`=0 → slots 1–3 have `selects`=0 throughout; slot 0 shows 7'b1101101. Set `dots`=4'b0010 → slot 1 shows 7'b0111111 with `dot`=1.
- **Enable:** drop `enable` mid-slot 2 → outputs are 0 on the next cycle. Raise `enable` → scan restarts at slot 0 with its blank cycle.
- **Async reset mid-frame:** assert `rst_n` mid-frame with a pending load → outputs clear immediately without waiting for `clk`. After release, 0 is displayed and the pending value is lost.
